// File: rtl/act_buf_pkg.sv
// Shared definitions for the activation-buffer reader/writer pair.
// Contents: buffer geometry and the reader FSM state encoding.
package act_buf_pkg;

    localparam int unsigned ACT_BYTES_PER_WORD = 2;
    localparam int unsigned ACT_BUF_DEPTH      = 8192;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/act_buf_stream_reader_if.sv
// Bus bundle for act_buf_stream_reader: writer sync handshake, ActBuf port 0
// read side, byte stream output and the end-of-transfer pulse.
// Optional feature macro: ACT_RD_TLAST_EN adds actOut_V_V_TLAST.
// Modports: master = reader side, slave = environment (writer/BRAM/sink).
interface act_buf_stream_reader_if #(
    parameter int unsigned AWIDTH = 13,
    parameter int unsigned DWIDTH = 16
);
    logic              SyncSig_V;
    logic              SyncSig_V_ap_vld;
    logic              SyncSig_V_ap_ack;
    logic [AWIDTH-1:0] ActBuf_Data_address0;
    logic              ActBuf_Data_ce0;
    logic [DWIDTH-1:0] ActBuf_Data_q0;
    logic [7:0]        actOut_V_V_TDATA;
    logic              actOut_V_V_TVALID;
    logic              actOut_V_V_TREADY;
`ifdef ACT_RD_TLAST_EN
    logic              actOut_V_V_TLAST;
`endif
    logic              rd_done;

    modport master (
        input  SyncSig_V,
        input  SyncSig_V_ap_vld,
        input  ActBuf_Data_q0,
        input  actOut_V_V_TREADY,
        output SyncSig_V_ap_ack,
        output ActBuf_Data_address0,
        output ActBuf_Data_ce0,
        output actOut_V_V_TDATA,
        output actOut_V_V_TVALID,
`ifdef ACT_RD_TLAST_EN
        output actOut_V_V_TLAST,
`endif
        output rd_done
    );

    modport slave (
        output SyncSig_V,
        output SyncSig_V_ap_vld,
        output ActBuf_Data_q0,
        output actOut_V_V_TREADY,
        input  SyncSig_V_ap_ack,
        input  ActBuf_Data_address0,
        input  ActBuf_Data_ce0,
        input  actOut_V_V_TDATA,
        input  actOut_V_V_TVALID,
`ifdef ACT_RD_TLAST_EN
        input  actOut_V_V_TLAST,
`endif
        input  rd_done
    );

endinterface

// File: rtl/act_buf_stream_reader_fifo.sv
// act_word_fifo2: 2-entry word FIFO between the BRAM read port and the byte
// unpacker. Simultaneous push and pop are allowed and leave count unchanged.
// Ports: clk, rst (sync, active-high), push/pushData, pop, head (oldest
// entry), count (0..2).
module act_word_fifo2 #(
    parameter int unsigned DWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DWIDTH-1:0] pushData,
    input  logic              pop,
    output logic [DWIDTH-1:0] head,
    output logic [1:0]        count
);
    logic [DWIDTH-1:0] mem [2];
    logic              wrPtr;
    logic              rdPtr;
    logic              doPush;
    logic              doPop;

    // Protect the pointers against a caller pushing when full or popping when empty
    assign doPop  = pop & (count != 2'd0);
    assign doPush = push & ((count != 2'd2) | doPop);
    assign head   = mem[rdPtr];

    // Storage and pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr  <= 1'b0;
            rdPtr  <= 1'b0;
            count  <= 2'd0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (doPush) begin
                mem[wrPtr] <= pushData;
                wrPtr      <= ~wrPtr;
            end
            if (doPop) begin
                rdPtr <= ~rdPtr;
            end
            count <= count + 2'(doPush) - 2'(doPop);
        end
    end

endmodule

// File: rtl/act_buf_stream_reader.sv
// act_buf_stream_reader: waits for the writer's SyncSig handshake, reads
// NUM_WORDS words from ActBuf port 0 (1-cycle read latency) and streams them
// low byte first on an 8-bit AXI-Stream, then pulses rd_done.
// Ports: ap_clk, ap_rst (sync, active-high); bus (master modport) carries
// SyncSig_V/_ap_vld/_ap_ack, ActBuf_Data_address0/ce0/q0,
// actOut_V_V_TDATA/TVALID/TREADY, rd_done.
// Optional feature macro: ACT_RD_TLAST_EN drives actOut_V_V_TLAST on the
// high byte of the final word.
module act_buf_stream_reader
    import act_buf_pkg::*;
#(
    parameter int unsigned AWIDTH    = 13,
    parameter int unsigned DWIDTH    = 16,
    parameter int unsigned NUM_WORDS = ACT_BUF_DEPTH
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    act_buf_stream_reader_if.master bus
);
    localparam int unsigned       BYTE_W    = DWIDTH / ACT_BYTES_PER_WORD;
    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(NUM_WORDS - 1);

    logic [1:0]        state;
    logic [1:0]        stateNxt;
    logic [AWIDTH-1:0] issueCnt;
    logic [AWIDTH-1:0] issueCntNxt;
    logic [AWIDTH-1:0] addrQ;
    logic [AWIDTH-1:0] addrNxt;
    logic [AWIDTH-1:0] popCnt;
    logic              ackQ;
    logic              ackNxt;
    logic              syncQ;
    logic              syncNxt;
    logic              ce0Q;
    logic              ce0Nxt;
    logic              pendQ;
    logic              doneQ;
    logic              doneNxt;
    logic              byteSel;

    logic [DWIDTH-1:0] head;
    logic [1:0]        count;
    logic              tvalid;
    logic              xfer;
    logic              popWord;
    logic              lastPop;
    logic [2:0]        creditUsed;
    logic              canIssue;
    logic              issueNow;

    // Word buffer; pendQ marks the cycle in which q0 carries a requested word
    act_word_fifo2 #(.DWIDTH(DWIDTH)) uFifo (
        .clk      (ap_clk),
        .rst      (ap_rst),
        .push     (pendQ),
        .pushData (bus.ActBuf_Data_q0),
        .pop      (popWord),
        .head     (head),
        .count    (count)
    );

    assign tvalid  = (count != 2'd0);
    assign xfer    = tvalid & bus.actOut_V_V_TREADY;
    assign popWord = xfer & byteSel;
    assign lastPop = popWord & (popCnt == LAST_ADDR);

    // ce0 is registered, so the decision made now shows up as next cycle's
    // fifo_count + inflight; counting this cycle's pop keeps 1 byte/cycle
    assign creditUsed = 3'(count) + 3'(pendQ) + 3'(ce0Q) - 3'(popWord);
    assign canIssue   = (creditUsed < 3'd2);

    // First read goes out during the ack cycle itself, keeping ack inside IDLE
    assign issueNow = ((state == ST_READ) & canIssue) |
                      ((state == ST_IDLE) & ackQ & syncQ);

    // Next-state and registered-output logic
    always_comb begin
        stateNxt    = state;
        issueCntNxt = issueCnt;
        addrNxt     = addrQ;
        ackNxt      = 1'b0;
        syncNxt     = syncQ;
        ce0Nxt      = 1'b0;
        doneNxt     = 1'b0;

        case (state)
            ST_IDLE: begin
                issueCntNxt = '0;
                if (!ackQ && bus.SyncSig_V_ap_vld) begin
                    ackNxt  = 1'b1;
                    syncNxt = bus.SyncSig_V;
                end
            end
            ST_READ: begin
            end
            ST_DRAIN: begin
                issueCntNxt = '0;
                if (lastPop) begin
                    doneNxt  = 1'b1;
                    stateNxt = ST_IDLE;
                end
            end
            default: begin
                stateNxt = ST_IDLE;
            end
        endcase

        if (issueNow) begin
            ce0Nxt  = 1'b1;
            addrNxt = issueCnt;
            if (issueCnt == LAST_ADDR) begin
                stateNxt = ST_DRAIN;
            end else begin
                issueCntNxt = issueCnt + AWIDTH'(1);
                stateNxt    = ST_READ;
            end
        end
    end

    // FSM and handshake registers
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state    <= ST_IDLE;
            issueCnt <= '0;
            addrQ    <= '0;
            ackQ     <= 1'b0;
            syncQ    <= 1'b0;
            ce0Q     <= 1'b0;
            pendQ    <= 1'b0;
            doneQ    <= 1'b0;
        end else begin
            state    <= stateNxt;
            issueCnt <= issueCntNxt;
            addrQ    <= addrNxt;
            ackQ     <= ackNxt;
            syncQ    <= syncNxt;
            ce0Q     <= ce0Nxt;
            pendQ    <= ce0Q;
            doneQ    <= doneNxt;
        end
    end

    // Byte unpacker: byte select and index of the word at the FIFO head
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            byteSel <= 1'b0;
            popCnt  <= '0;
        end else begin
            if (xfer) begin
                byteSel <= ~byteSel;
            end
            if (lastPop) begin
                popCnt <= '0;
            end else if (popWord) begin
                popCnt <= popCnt + AWIDTH'(1);
            end
        end
    end

    assign bus.SyncSig_V_ap_ack     = ackQ;
    assign bus.ActBuf_Data_ce0      = ce0Q;
    assign bus.ActBuf_Data_address0 = addrQ;
    assign bus.rd_done              = doneQ;
    assign bus.actOut_V_V_TVALID    = tvalid;
    // Zero when empty so TDATA reads 0 out of reset
    assign bus.actOut_V_V_TDATA     = tvalid ? (byteSel ? head[2*BYTE_W-1:BYTE_W]
                                                        : head[BYTE_W-1:0])
                                             : 8'd0;
`ifdef ACT_RD_TLAST_EN
    assign bus.actOut_V_V_TLAST     = tvalid & byteSel & (popCnt == LAST_ADDR);
`endif

endmodule
